// File: rtl/axil_gpio_pkg.sv
// Shared definitions for the AXI4-Lite GPIO block: register map, response codes,
// FSM state types and the byte-lane merge helper.
package axil_gpio_pkg;

  localparam logic [31:0] OFF_DATA  = 32'h000;
  localparam logic [31:0] OFF_TRI   = 32'h004;
  localparam logic [31:0] CH_STRIDE = 32'h010;
  localparam logic [31:0] OFF_GIER  = 32'h11C;
  localparam logic [31:0] OFF_ISR   = 32'h120;
  localparam logic [31:0] OFF_IER   = 32'h128;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic {W_IDLE, W_RESP} wState_e;
  typedef enum logic {R_IDLE, R_DATA} rState_e;

  typedef enum logic [2:0] {
    SEL_NONE,
    SEL_DATA,
    SEL_TRI,
    SEL_GIER,
    SEL_ISR,
    SEL_IER
  } regSel_e;

  typedef struct packed {
    regSel_e    sel;
    logic [1:0] ch;
  } regHit_t;

  // Replace only the byte lanes whose strobe bit is set.
  function automatic logic [31:0] mergeStrb(input logic [31:0] oldVal,
                                            input logic [31:0] newVal,
                                            input logic [3:0]  strb);
    logic [31:0] result;
    for (int i = 0; i < 4; i++) begin
      result[i*8 +: 8] = strb[i] ? newVal[i*8 +: 8] : oldVal[i*8 +: 8];
    end
    return result;
  endfunction

endpackage

// File: rtl/axil_gpio_sync.sv
// Parametrised-width two-flop synchroniser for asynchronous GPIO inputs.
module axil_gpio_sync
  import axil_gpio_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_o
);

  logic [WIDTH-1:0] metaStage_q;
  logic [WIDTH-1:0] syncStage_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      metaStage_q <= '0;
      syncStage_q <= '0;
    end else begin
      metaStage_q <= d_i;
      syncStage_q <= metaStage_q;
    end
  end

  assign q_o = syncStage_q;

endmodule

// File: rtl/axil_gpio_n.sv
// Multi-channel AXI4-Lite GPIO with per-channel DATA/TRI registers.
// Optional change-detect interrupt block enabled by defining AXIL_GPIO_N_IRQ_EN.
module axil_gpio_n
  import axil_gpio_pkg::*;
#(
  parameter int GPIO_WIDTH = 8,
  parameter int NUM_CH     = 2,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                         s_axi_aclk,
  input  logic                         s_axi_aresetn,
  input  logic [ADDR_WIDTH-1:0]        s_axi_awaddr,
  input  logic                         s_axi_awvalid,
  output logic                         s_axi_awready,
  input  logic [31:0]                  s_axi_wdata,
  input  logic [3:0]                   s_axi_wstrb,
  input  logic                         s_axi_wvalid,
  output logic                         s_axi_wready,
  output logic [1:0]                   s_axi_bresp,
  output logic                         s_axi_bvalid,
  input  logic                         s_axi_bready,
  input  logic [ADDR_WIDTH-1:0]        s_axi_araddr,
  input  logic                         s_axi_arvalid,
  output logic                         s_axi_arready,
  output logic [31:0]                  s_axi_rdata,
  output logic [1:0]                   s_axi_rresp,
  output logic                         s_axi_rvalid,
  input  logic                         s_axi_rready,
  input  logic [NUM_CH*GPIO_WIDTH-1:0] gpio_io_i,
  output logic [NUM_CH*GPIO_WIDTH-1:0] gpio_io_o,
  output logic [NUM_CH*GPIO_WIDTH-1:0] gpio_io_t,
  output logic                         ip2intc_irpt
);

  typedef logic [NUM_CH-1:0][GPIO_WIDTH-1:0] chVec_t;

  wState_e     wState_q, wState_d;
  rState_e     rState_q, rState_d;
  chVec_t      dataReg_q, dataReg_d;
  chVec_t      triReg_q, triReg_d;
  chVec_t      gpioSync;
  logic [1:0]  bresp_q, bresp_d;
  logic [1:0]  rresp_q, rresp_d;
  logic [31:0] rdata_q, rdata_d;
  logic        wrAccept;
  logic        rdAccept;
  regHit_t     wrHit;
  regHit_t     rdHit;

`ifdef AXIL_GPIO_N_IRQ_EN
  chVec_t             gpioPrev_q;
  logic               gierReg_q, gierReg_d;
  logic [NUM_CH-1:0]  ierReg_q, ierReg_d;
  logic [NUM_CH-1:0]  isrReg_q, isrReg_d;
  logic [NUM_CH-1:0]  isrClr;
  logic [NUM_CH-1:0]  chChange;
`endif

  // Full-address decode; anything not matching a live register is an error slot.
  function automatic regHit_t decode(input logic [ADDR_WIDTH-1:0] addr);
    logic [31:0] a;
    regHit_t     hit;
    a       = 32'(addr);
    hit.sel = SEL_NONE;
    hit.ch  = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      if (a == CH_STRIDE * 32'(c) + OFF_DATA) begin
        hit.sel = SEL_DATA;
        hit.ch  = 2'(c);
      end
      if (a == CH_STRIDE * 32'(c) + OFF_TRI) begin
        hit.sel = SEL_TRI;
        hit.ch  = 2'(c);
      end
    end
`ifdef AXIL_GPIO_N_IRQ_EN
    if (a == OFF_GIER) hit.sel = SEL_GIER;
    if (a == OFF_ISR)  hit.sel = SEL_ISR;
    if (a == OFF_IER)  hit.sel = SEL_IER;
`endif
    return hit;
  endfunction

  axil_gpio_sync #(
    .WIDTH(NUM_CH * GPIO_WIDTH)
  ) u_sync (
    .clk_i (s_axi_aclk),
    .rst_ni(s_axi_aresetn),
    .d_i   (gpio_io_i),
    .q_o   (gpioSync)
  );

  assign wrHit    = decode(s_axi_awaddr);
  assign rdHit    = decode(s_axi_araddr);
  assign wrAccept = s_axi_aresetn && (wState_q == W_IDLE) && s_axi_awvalid && s_axi_wvalid;
  assign rdAccept = s_axi_aresetn && (rState_q == R_IDLE) && s_axi_arvalid;

  // Write channel: one-cycle ready pulse, then hold the response until bready.
  always_comb begin
    wState_d  = wState_q;
    bresp_d   = bresp_q;
    dataReg_d = dataReg_q;
    triReg_d  = triReg_q;
`ifdef AXIL_GPIO_N_IRQ_EN
    gierReg_d = gierReg_q;
    ierReg_d  = ierReg_q;
    isrClr    = '0;
`endif
    case (wState_q)
      W_IDLE: begin
        if (wrAccept) begin
          wState_d = W_RESP;
          bresp_d  = (wrHit.sel == SEL_NONE) ? RESP_SLVERR : RESP_OKAY;
          for (int c = 0; c < NUM_CH; c++) begin
            if (wrHit.ch == 2'(c)) begin
              case (wrHit.sel)
                SEL_DATA: dataReg_d[c] = GPIO_WIDTH'(mergeStrb(32'(dataReg_q[c]), s_axi_wdata, s_axi_wstrb));
                SEL_TRI:  triReg_d[c]  = GPIO_WIDTH'(mergeStrb(32'(triReg_q[c]), s_axi_wdata, s_axi_wstrb));
                default: ;
              endcase
            end
          end
`ifdef AXIL_GPIO_N_IRQ_EN
          case (wrHit.sel)
            SEL_GIER: if (s_axi_wstrb[3]) gierReg_d = s_axi_wdata[31];
            SEL_IER:  if (s_axi_wstrb[0]) ierReg_d = s_axi_wdata[NUM_CH-1:0];
            SEL_ISR:  if (s_axi_wstrb[0]) isrClr = s_axi_wdata[NUM_CH-1:0];
            default: ;
          endcase
`endif
        end
      end
      W_RESP: begin
        if (s_axi_bready) wState_d = W_IDLE;
      end
      default: wState_d = W_IDLE;
    endcase
  end

  // Read channel: capture from current register state, so a same-cycle write is not seen.
  always_comb begin
    rState_d = rState_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    case (rState_q)
      R_IDLE: begin
        if (rdAccept) begin
          rState_d = R_DATA;
          rresp_d  = RESP_OKAY;
          rdata_d  = '0;
          case (rdHit.sel)
            SEL_DATA: begin
              for (int c = 0; c < NUM_CH; c++) begin
                if (rdHit.ch == 2'(c))
                  rdata_d = 32'((gpioSync[c] & triReg_q[c]) | (dataReg_q[c] & ~triReg_q[c]));
              end
            end
            SEL_TRI: begin
              for (int c = 0; c < NUM_CH; c++) begin
                if (rdHit.ch == 2'(c)) rdata_d = 32'(triReg_q[c]);
              end
            end
`ifdef AXIL_GPIO_N_IRQ_EN
            SEL_GIER: rdata_d = {gierReg_q, 31'b0};
            SEL_IER:  rdata_d = 32'(ierReg_q);
            SEL_ISR:  rdata_d = 32'(isrReg_q);
`endif
            default:  rresp_d = RESP_SLVERR;
          endcase
        end
      end
      R_DATA: begin
        if (s_axi_rready) rState_d = R_IDLE;
      end
      default: rState_d = R_IDLE;
    endcase
  end

`ifdef AXIL_GPIO_N_IRQ_EN
  // A new change event wins over a simultaneous clear so no edge is lost.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      chChange[c] = |(gpioSync[c] ^ gpioPrev_q[c]);
    end
    isrReg_d = (isrReg_q & ~isrClr) | chChange;
  end
`endif

  always_ff @(posedge s_axi_aclk) begin
    if (!s_axi_aresetn) begin
      wState_q  <= W_IDLE;
      rState_q  <= R_IDLE;
      dataReg_q <= '0;
      triReg_q  <= '1;
      bresp_q   <= RESP_OKAY;
      rresp_q   <= RESP_OKAY;
      rdata_q   <= '0;
`ifdef AXIL_GPIO_N_IRQ_EN
      gpioPrev_q <= '0;
      gierReg_q  <= 1'b0;
      ierReg_q   <= '0;
      isrReg_q   <= '0;
`endif
    end else begin
      wState_q  <= wState_d;
      rState_q  <= rState_d;
      dataReg_q <= dataReg_d;
      triReg_q  <= triReg_d;
      bresp_q   <= bresp_d;
      rresp_q   <= rresp_d;
      rdata_q   <= rdata_d;
`ifdef AXIL_GPIO_N_IRQ_EN
      gpioPrev_q <= gpioSync;
      gierReg_q  <= gierReg_d;
      ierReg_q   <= ierReg_d;
      isrReg_q   <= isrReg_d;
`endif
    end
  end

  assign s_axi_awready = wrAccept;
  assign s_axi_wready  = wrAccept;
  assign s_axi_arready = rdAccept;
  assign s_axi_bvalid  = s_axi_aresetn && (wState_q == W_RESP);
  assign s_axi_rvalid  = s_axi_aresetn && (rState_q == R_DATA);
  assign s_axi_bresp   = bresp_q;
  assign s_axi_rresp   = rresp_q;
  assign s_axi_rdata   = rdata_q;
  assign gpio_io_o     = dataReg_q;
  assign gpio_io_t     = triReg_q;

`ifdef AXIL_GPIO_N_IRQ_EN
  assign ip2intc_irpt = s_axi_aresetn & gierReg_q & (|(isrReg_q & ierReg_q));
`else
  assign ip2intc_irpt = 1'b0;
`endif

endmodule

// File: tb/tb_axil_gpio_n.sv
// Directed self-checking bench for axil_gpio_n (default parameters).
// Covers the interrupt block when AXIL_GPIO_N_IRQ_EN is defined, its absence otherwise.
module tb_axil_gpio_n;

  localparam int GPIO_WIDTH = 8;
  localparam int NUM_CH     = 2;
  localparam int ADDR_WIDTH = 9;
  localparam int TW         = NUM_CH * GPIO_WIDTH;

  logic                  s_axi_aclk = 1'b0;
  logic                  s_axi_aresetn;
  logic [ADDR_WIDTH-1:0] s_axi_awaddr;
  logic                  s_axi_awvalid;
  logic                  s_axi_awready;
  logic [31:0]           s_axi_wdata;
  logic [3:0]            s_axi_wstrb;
  logic                  s_axi_wvalid;
  logic                  s_axi_wready;
  logic [1:0]            s_axi_bresp;
  logic                  s_axi_bvalid;
  logic                  s_axi_bready;
  logic [ADDR_WIDTH-1:0] s_axi_araddr;
  logic                  s_axi_arvalid;
  logic                  s_axi_arready;
  logic [31:0]           s_axi_rdata;
  logic [1:0]            s_axi_rresp;
  logic                  s_axi_rvalid;
  logic                  s_axi_rready;
  logic [TW-1:0]         gpio_io_i;
  logic [TW-1:0]         gpio_io_o;
  logic [TW-1:0]         gpio_io_t;
  logic                  ip2intc_irpt;

  int checkCount = 0;
  int errorCount = 0;

  axil_gpio_n #(
    .GPIO_WIDTH(GPIO_WIDTH),
    .NUM_CH    (NUM_CH),
    .ADDR_WIDTH(ADDR_WIDTH)
  ) dut (
    .s_axi_aclk   (s_axi_aclk),
    .s_axi_aresetn(s_axi_aresetn),
    .s_axi_awaddr (s_axi_awaddr),
    .s_axi_awvalid(s_axi_awvalid),
    .s_axi_awready(s_axi_awready),
    .s_axi_wdata  (s_axi_wdata),
    .s_axi_wstrb  (s_axi_wstrb),
    .s_axi_wvalid (s_axi_wvalid),
    .s_axi_wready (s_axi_wready),
    .s_axi_bresp  (s_axi_bresp),
    .s_axi_bvalid (s_axi_bvalid),
    .s_axi_bready (s_axi_bready),
    .s_axi_araddr (s_axi_araddr),
    .s_axi_arvalid(s_axi_arvalid),
    .s_axi_arready(s_axi_arready),
    .s_axi_rdata  (s_axi_rdata),
    .s_axi_rresp  (s_axi_rresp),
    .s_axi_rvalid (s_axi_rvalid),
    .s_axi_rready (s_axi_rready),
    .gpio_io_i    (gpio_io_i),
    .gpio_io_o    (gpio_io_o),
    .gpio_io_t    (gpio_io_t),
    .ip2intc_irpt (ip2intc_irpt)
  );

  always #5 s_axi_aclk = ~s_axi_aclk;

  // Single comparison point: counts every check and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s observed 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive the GPIO pins and give the synchroniser time to settle.
  task automatic applyStimulus(input logic [TW-1:0] pins);
    @(negedge s_axi_aclk);
    gpio_io_i = pins;
    repeat (3) @(negedge s_axi_aclk);
  endtask

  task automatic axiWrite(input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, output logic [1:0] resp);
    int n;
    @(negedge s_axi_aclk);
    s_axi_awaddr  = addr[ADDR_WIDTH-1:0];
    s_axi_wdata   = data;
    s_axi_wstrb   = strb;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    #1;
    n = 0;
    while (!(s_axi_awready && s_axi_wready) && n < 20) begin
      @(negedge s_axi_aclk);
      #1;
      n++;
    end
    checkOutput("awHandshake", 32'(s_axi_awready & s_axi_wready), 32'd1);
    @(posedge s_axi_aclk);
    #1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    @(negedge s_axi_aclk);
    n = 0;
    while (!s_axi_bvalid && n < 20) begin
      @(negedge s_axi_aclk);
      n++;
    end
    checkOutput("bvalidSeen", 32'(s_axi_bvalid), 32'd1);
    resp = s_axi_bresp;
    s_axi_bready = 1'b1;
    @(posedge s_axi_aclk);
    #1;
    s_axi_bready = 1'b0;
  endtask

  task automatic axiRead(input logic [31:0] addr, output logic [31:0] data, output logic [1:0] resp);
    int n;
    @(negedge s_axi_aclk);
    s_axi_araddr  = addr[ADDR_WIDTH-1:0];
    s_axi_arvalid = 1'b1;
    #1;
    n = 0;
    while (!s_axi_arready && n < 20) begin
      @(negedge s_axi_aclk);
      #1;
      n++;
    end
    checkOutput("arHandshake", 32'(s_axi_arready), 32'd1);
    @(posedge s_axi_aclk);
    #1;
    s_axi_arvalid = 1'b0;
    @(negedge s_axi_aclk);
    n = 0;
    while (!s_axi_rvalid && n < 20) begin
      @(negedge s_axi_aclk);
      n++;
    end
    checkOutput("rvalidSeen", 32'(s_axi_rvalid), 32'd1);
    data = s_axi_rdata;
    resp = s_axi_rresp;
    s_axi_rready = 1'b1;
    @(posedge s_axi_aclk);
    #1;
    s_axi_rready = 1'b0;
  endtask

  initial begin
    logic [1:0]  resp;
    logic [31:0] rd;
    int          n;

    s_axi_aresetn = 1'b0;
    s_axi_awaddr  = '0;
    s_axi_wdata   = '0;
    s_axi_wstrb   = '0;
    s_axi_araddr  = '0;
    s_axi_bready  = 1'b0;
    s_axi_rready  = 1'b0;
    gpio_io_i     = '0;
    // Valid requests during reset must not be acknowledged.
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    s_axi_arvalid = 1'b1;
    repeat (3) @(negedge s_axi_aclk);
    checkOutput("rstAwready", 32'(s_axi_awready), 32'd0);
    checkOutput("rstWready", 32'(s_axi_wready), 32'd0);
    checkOutput("rstArready", 32'(s_axi_arready), 32'd0);
    checkOutput("rstBvalid", 32'(s_axi_bvalid), 32'd0);
    checkOutput("rstRvalid", 32'(s_axi_rvalid), 32'd0);
    checkOutput("rstIrq", 32'(ip2intc_irpt), 32'd0);
    checkOutput("rstRdata", s_axi_rdata, 32'd0);
    checkOutput("rstResp", {28'b0, s_axi_bresp, s_axi_rresp}, 32'd0);
    checkOutput("rstGpioO", 32'(gpio_io_o), 32'h0000);
    checkOutput("rstGpioT", 32'(gpio_io_t), 32'hFFFF);
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    s_axi_arvalid = 1'b0;
    @(negedge s_axi_aclk);
    s_axi_aresetn = 1'b1;

    // Basic output drive on channel 0.
    axiWrite(32'h0, 32'h0000_00A5, 4'hF, resp);
    checkOutput("wrData0Resp", 32'(resp), 32'd0);
    axiWrite(32'h4, 32'h0, 4'hF, resp);
    checkOutput("wrTri0Resp", 32'(resp), 32'd0);
    checkOutput("gpioO0", 32'(gpio_io_o[7:0]), 32'hA5);
    checkOutput("gpioT0", 32'(gpio_io_t[7:0]), 32'h00);
    axiRead(32'h0, rd, resp);
    checkOutput("rdData0", rd, 32'hA5);
    checkOutput("rdData0Resp", 32'(resp), 32'd0);

    // Channel 1 as input.
    axiWrite(32'h14, 32'hFF, 4'hF, resp);
    applyStimulus(16'h3C00);
    checkOutput("gpioT1", 32'(gpio_io_t[15:8]), 32'hFF);
    axiRead(32'h10, rd, resp);
    checkOutput("rdIn1", rd, 32'h3C);
    checkOutput("rdIn1Resp", 32'(resp), 32'd0);

    // Byte-lane strobes and width masking.
    axiWrite(32'h0, 32'h0, 4'hF, resp);
    axiWrite(32'h0, 32'hFFFF_FFFF, 4'h2, resp);
    axiRead(32'h0, rd, resp);
    checkOutput("strbLane1", rd, 32'h00);
    axiWrite(32'h0, 32'hFFFF_FFFF, 4'h1, resp);
    axiRead(32'h0, rd, resp);
    checkOutput("strbLane0", rd, 32'hFF);
    checkOutput("strbGpioO", 32'(gpio_io_o[7:0]), 32'hFF);

    // Mixed direction: upper nibble from pins, lower nibble from DATA.
    axiWrite(32'h4, 32'hF0, 4'hF, resp);
    applyStimulus(16'h3C5A);
    axiRead(32'h0, rd, resp);
    checkOutput("rdMixed", rd, 32'h5F);
    axiRead(32'h4, rd, resp);
    checkOutput("rdTri0", rd, 32'hF0);

    // Write response back-pressure; a second write waits behind it.
    @(negedge s_axi_aclk);
    s_axi_awaddr  = 9'h010;
    s_axi_wdata   = 32'h33;
    s_axi_wstrb   = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    #1;
    checkOutput("stallAw1", 32'(s_axi_awready), 32'd1);
    @(posedge s_axi_aclk);
    #1;
    s_axi_wdata = 32'h44;
    for (int i = 0; i < 5; i++) begin
      @(negedge s_axi_aclk);
      checkOutput("stallBvalid", 32'(s_axi_bvalid), 32'd1);
      checkOutput("stallBresp", 32'(s_axi_bresp), 32'd0);
      checkOutput("stallAwBlocked", 32'(s_axi_awready), 32'd0);
    end
    checkOutput("stallData1", 32'(gpio_io_o[15:8]), 32'h33);
    s_axi_bready = 1'b1;
    @(posedge s_axi_aclk);
    #1;
    s_axi_bready = 1'b0;
    @(negedge s_axi_aclk);
    checkOutput("stallAw2", 32'(s_axi_awready), 32'd1);
    @(posedge s_axi_aclk);
    #1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    @(negedge s_axi_aclk);
    checkOutput("stallBvalid2", 32'(s_axi_bvalid), 32'd1);
    s_axi_bready = 1'b1;
    @(posedge s_axi_aclk);
    #1;
    s_axi_bready = 1'b0;
    checkOutput("stallData2", 32'(gpio_io_o[15:8]), 32'h44);

    // Read data back-pressure; pins change but held rdata must not.
    @(negedge s_axi_aclk);
    s_axi_araddr  = 9'h000;
    s_axi_arvalid = 1'b1;
    #1;
    checkOutput("stallAr", 32'(s_axi_arready), 32'd1);
    @(posedge s_axi_aclk);
    #1;
    s_axi_arvalid   = 1'b0;
    gpio_io_i[7:0]  = 8'h00;
    for (int i = 0; i < 5; i++) begin
      @(negedge s_axi_aclk);
      checkOutput("stallRvalid", 32'(s_axi_rvalid), 32'd1);
      checkOutput("stallRdata", s_axi_rdata, 32'h5F);
    end
    s_axi_rready = 1'b1;
    @(posedge s_axi_aclk);
    #1;
    s_axi_rready = 1'b0;
    @(negedge s_axi_aclk);
    checkOutput("stallRdone", 32'(s_axi_rvalid), 32'd0);

    // Unmapped address and out-of-range channel.
    axiWrite(32'h40, 32'hFFFF_FFFF, 4'hF, resp);
    checkOutput("wrUnmapResp", 32'(resp), 32'd2);
    checkOutput("wrUnmapGpioO", 32'(gpio_io_o), 32'h44FF);
    checkOutput("wrUnmapGpioT", 32'(gpio_io_t), 32'hFFF0);
    axiRead(32'h40, rd, resp);
    checkOutput("rdUnmapResp", 32'(resp), 32'd2);
    checkOutput("rdUnmapData", rd, 32'd0);
    axiRead(32'h20, rd, resp);
    checkOutput("rdCh2Resp", 32'(resp), 32'd2);
    axiRead(32'h8, rd, resp);
    checkOutput("rdGapResp", 32'(resp), 32'd2);

`ifdef AXIL_GPIO_N_IRQ_EN
    axiWrite(32'h11C, 32'h8000_0000, 4'hF, resp);
    checkOutput("gierResp", 32'(resp), 32'd0);
    axiWrite(32'h120, 32'h3, 4'hF, resp);
    axiWrite(32'h128, 32'h1, 4'hF, resp);
    checkOutput("irqIdle", 32'(ip2intc_irpt), 32'd0);
    axiRead(32'h128, rd, resp);
    checkOutput("rdIer", rd, 32'h1);
    @(negedge s_axi_aclk);
    gpio_io_i[0] = ~gpio_io_i[0];
    n = 0;
    while (!ip2intc_irpt && n < 3) begin
      @(negedge s_axi_aclk);
      n++;
    end
    checkOutput("irqRaised", 32'(ip2intc_irpt), 32'd1);
    axiRead(32'h120, rd, resp);
    checkOutput("rdIsr", rd, 32'h1);
    axiWrite(32'h120, 32'h1, 4'hF, resp);
    @(negedge s_axi_aclk);
    checkOutput("irqCleared", 32'(ip2intc_irpt), 32'd0);
`else
    axiWrite(32'h11C, 32'h8000_0000, 4'hF, resp);
    checkOutput("gierSlverr", 32'(resp), 32'd2);
    axiRead(32'h120, rd, resp);
    checkOutput("isrSlverr", 32'(resp), 32'd2);
    axiRead(32'h128, rd, resp);
    checkOutput("ierSlverr", 32'(resp), 32'd2);
    applyStimulus(gpio_io_i ^ 16'h0001);
    checkOutput("irqTiedLow", 32'(ip2intc_irpt), 32'd0);
`endif

    // Reset while a write response is pending.
    @(negedge s_axi_aclk);
    s_axi_awaddr  = 9'h000;
    s_axi_wdata   = 32'h12;
    s_axi_wstrb   = 4'hF;
    s_axi_awvalid = 1'b1;
    s_axi_wvalid  = 1'b1;
    #1;
    checkOutput("rstMidAw", 32'(s_axi_awready), 32'd1);
    @(posedge s_axi_aclk);
    #1;
    s_axi_awvalid = 1'b0;
    s_axi_wvalid  = 1'b0;
    @(negedge s_axi_aclk);
    checkOutput("rstMidBvalid", 32'(s_axi_bvalid), 32'd1);
    checkOutput("rstMidGpioO", 32'(gpio_io_o[7:0]), 32'h12);
    s_axi_aresetn = 1'b0;
    @(posedge s_axi_aclk);
    #1;
    checkOutput("rstMidBvalidLow", 32'(s_axi_bvalid), 32'd0);
    checkOutput("rstMidGpioOClr", 32'(gpio_io_o), 32'h0000);
    checkOutput("rstMidGpioTSet", 32'(gpio_io_t), 32'hFFFF);
    @(negedge s_axi_aclk);
    s_axi_aresetn = 1'b1;
    repeat (2) begin
      @(negedge s_axi_aclk);
      checkOutput("rstMidNoResp", 32'(s_axi_bvalid), 32'd0);
    end
    axiWrite(32'h4, 32'h0, 4'hF, resp);
    checkOutput("postRstResp", 32'(resp), 32'd0);
    axiRead(32'h0, rd, resp);
    checkOutput("postRstData", rd, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/axil_gpio_n.md
AXIL_GPIO_N -- requirements
Module: axil_gpio_n

Interface
REQ-001 SHALL have parameter GPIO_WIDTH, default 8, bits per channel (1..32).
REQ-002 SHALL have parameter NUM_CH, default 2, channel count (1..4).
REQ-003 SHALL have parameter ADDR_WIDTH, default 9, AXI4-Lite address width.
REQ-004 SHALL have ports s_axi_aclk in 1 (sole clock) and s_axi_aresetn in 1 (reset, synchronous, active-low).
REQ-005 SHALL have ports s_axi_awaddr in ADDR_WIDTH, s_axi_awvalid in 1, s_axi_awready out 1 (write address).
REQ-006 SHALL have ports s_axi_wdata in 32, s_axi_wstrb in 4, s_axi_wvalid in 1, s_axi_wready out 1 (write data).
REQ-007 SHALL have ports s_axi_bresp out 2, s_axi_bvalid out 1, s_axi_bready in 1 (write response).
REQ-008 SHALL have ports s_axi_araddr in ADDR_WIDTH, s_axi_arvalid in 1, s_axi_arready out 1 (read address).
REQ-009 SHALL have ports s_axi_rdata out 32, s_axi_rresp out 2, s_axi_rvalid out 1, s_axi_rready in 1 (read data).
REQ-010 SHALL have ports gpio_io_i in, gpio_io_o out and gpio_io_t out, each NUM_CH*GPIO_WIDTH (channel c = bits [c*GPIO_WIDTH +: GPIO_WIDTH]; t=1 means input), plus ip2intc_irpt out 1.

Function
REQ-011 SHALL decode channel c registers as DATA at 0x10*c+0x0 and TRI at 0x10*c+0x4; IRQ registers GIER 0x11C, IER 0x128, ISR 0x120.
REQ-012 SHALL accept a write only when awvalid and wvalid are both high; awready and wready pulse high together for exactly one cycle.
REQ-013 SHALL raise bvalid the cycle after acceptance, hold bvalid/bresp until bready, and accept no new write while bvalid is high.
REQ-014 SHALL use write FSM W_IDLE -> W_RESP (on accept) -> W_IDLE (on bvalid&bready).
REQ-015 SHALL pulse arready one cycle on arvalid, then present rvalid/rdata/rresp the next cycle, held stable until rready (FSM R_IDLE -> R_DATA -> R_IDLE).
REQ-016 SHALL run read and write FSMs independently; a read accepted in the same cycle a write updates the same register returns the pre-write value.
REQ-017 SHALL honour wstrb per byte lane; unwritten lanes keep their value; bits above GPIO_WIDTH are ignored on write and read as 0.
REQ-018 SHALL answer OKAY (2'b00) for mapped addresses and SLVERR (2'b10) for unmapped addresses or channels >= NUM_CH, with no register change and rdata 0.
REQ-019 SHALL drive gpio_io_o from DATA and gpio_io_t from TRI combinationally from registers (one cycle after write acceptance).
REQ-020 SHALL synchronise gpio_io_i through two flops; a DATA read returns synced input where TRI=1 and DATA register where TRI=0.

Reset
REQ-021 SHALL, on s_axi_aresetn=0 at a clock edge, clear DATA, IER, ISR, GIER and set TRI all-ones (gpio_io_o=0, gpio_io_t=all 1).
REQ-022 SHALL drive awready, wready, arready, bvalid, rvalid, ip2intc_irpt to 0, bresp/rresp to 0, rdata to 0 during reset.
REQ-023 SHALL abandon any in-flight transaction on reset mid-operation and return both FSMs to IDLE without issuing a response.

Configuration
REQ-024 SHALL, with AXIL_GPIO_N_IRQ_EN defined, set ISR bit c when any synced input bit of channel c changes, clear ISR bits by writing 1, and drive ip2intc_irpt = GIER[31] & |(ISR & IER).
REQ-025 SHALL, without AXIL_GPIO_N_IRQ_EN, omit change-detect logic, tie ip2intc_irpt to 0 and answer SLVERR at 0x11C/0x120/0x128.

Structure
REQ-026 SHALL place register offsets, response codes (OKAY, SLVERR) and FSM state typedefs in package axil_gpio_pkg.
REQ-027 SHALL instantiate sub-module axil_gpio_sync (parametrised-width two-flop synchroniser) for gpio_io_i.

Verification
REQ-028 Write 0x000000A5, wstrb 0xF to 0x0 and 0x0 to 0x4 -> gpio_io_o[7:0]=0xA5, gpio_io_t[7:0]=0x00, bresp OKAY.
REQ-029 TRI ch1=0xFF, drive gpio_io_i[15:8]=0x3C, read 0x10 after 3 cycles -> rdata 0x0000003C, rresp OKAY.
REQ-030 Write 0xFFFF_FFFF wstrb 0x2 to 0x0 after DATA=0x00 -> DATA reads 0x0000FF00 masked to GPIO_WIDTH=8 -> 0x00; wstrb 0x1 -> 0xFF.
REQ-031 Hold bready/rready low 5 cycles -> bvalid/rvalid and data stable; second awvalid not accepted until B completes.
REQ-032 Write/read 0x40 with NUM_CH=2 -> SLVERR, outputs unchanged; assert reset during W_RESP -> bvalid 0, outputs at reset values.
REQ-033 With AXIL_GPIO_N_IRQ_EN, GIER=0x80000000, IER=0x1, toggle ch0 input -> ip2intc_irpt=1 within 3 cycles; write ISR 0x1 -> irpt 0.
